// File: rtl/tlul_dev_pkg.sv
// -----------------------------------------------------------------------------
// tlul_dev_pkg
// Types shared by the TL-UL device responder and its legality checker:
//   state_e     : responder FSM state (IDLE / ACCESS / RESP).
//   err_cause_e : why a transaction was answered with d_error.
//   lane_mask() : byte lanes covered by an aligned access of a given size.
// -----------------------------------------------------------------------------
package tlul_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_OPCODE  = 3'd1,
        ERR_ALIGN   = 3'd2,
        ERR_MASK    = 3'd3,
        ERR_RANGE   = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_cause_e;

    // Lanes touched by an access of 2**size bytes at byte offset addr_lo.
    // Only meaningful for size <= 2 and an address already aligned to size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            2'd0:    lane_mask = 4'b0001 << addr_lo;
            2'd1:    lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// TL-UL channel definitions shared by hosts and devices on the bus.
//   tl_h2d_t : A channel (host -> device) plus the host's d_ready.
//   tl_d2h_t : D channel (device -> host) plus the device's a_ready.
// Opcode constants are plain localparams so that illegal opcodes can still be
// carried on the bus and reported as errors by the receiving device.
// -----------------------------------------------------------------------------
package tlul_pkg;

    localparam logic [2:0] OpPutFullData    = 3'd0;
    localparam logic [2:0] OpPutPartialData = 3'd1;
    localparam logic [2:0] OpGet            = 3'd4;

    localparam logic [2:0] OpAccessAck      = 3'd0;
    localparam logic [2:0] OpAccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_dev_responder_if.sv
// -----------------------------------------------------------------------------
// tlul_dev_responder_if
// Bundles the TL-UL request/response structs of one host-device link.
//   h2d : A channel + d_ready, driven by the host.
//   d2h : D channel + a_ready, driven by the device.
// Handshake rule on both channels: a beat transfers on a rising clock edge
// where valid and ready are both high; the sender keeps valid and every
// payload field stable until that edge, and ready may depend on state only.
// Modports: master (host side), slave (device side).
// -----------------------------------------------------------------------------
interface tlul_dev_responder_if;
    import tlul_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);

endinterface

// File: rtl/tlul_dev_err_chk.sv
// -----------------------------------------------------------------------------
// tlul_dev_err_chk
// Combinational legality check of one TL-UL A beat against the device window.
// Inputs : a_opcode, a_size, a_address, a_mask (A channel fields).
// Outputs: err_o   - beat must be answered with d_error and no register access.
//          cause_o - first failing rule, checked in the order
//                    opcode, size/alignment, mask, address window.
// -----------------------------------------------------------------------------
module tlul_dev_err_chk
    import tlul_pkg::*;
    import tlul_dev_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0,
    parameter logic [31:0] AddrMask = 32'h0000_0FFF
) (
    input  logic [2:0]  a_opcode,
    input  logic [1:0]  a_size,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    output logic        err_o,
    output err_cause_e  cause_o
);

    logic opcode_ok;
    logic misaligned;
    logic mask_bad;
    logic range_hit;

    assign opcode_ok  = (a_opcode == OpGet) || (a_opcode == OpPutFullData) ||
                        (a_opcode == OpPutPartialData);
    assign misaligned = ((a_size == 2'd1) && a_address[0]) ||
                        ((a_size == 2'd2) && (a_address[1:0] != 2'b00));
    // A full put must cover exactly the lanes of its size; every beat needs
    // at least one lane enabled.
    assign mask_bad   = (a_mask == 4'b0000) ||
                        ((a_opcode == OpPutFullData) &&
                         (a_mask != lane_mask(a_size, a_address[1:0])));
    assign range_hit  = (a_address & ~AddrMask) == BaseAddr;

    always_comb begin
        cause_o = ERR_NONE;
        if (!opcode_ok) begin
            cause_o = ERR_OPCODE;
        end else if ((a_size > 2'd2) || misaligned) begin
            cause_o = ERR_ALIGN;
        end else if (mask_bad) begin
            cause_o = ERR_MASK;
        end else if (!range_hit) begin
            cause_o = ERR_RANGE;
        end
    end

    assign err_o = (cause_o != ERR_NONE);

endmodule

// File: rtl/tlul_dev_responder.sv
// -----------------------------------------------------------------------------
// tlul_dev_responder
// TL-UL device front end that turns one A beat at a time into a simple
// register access and returns the matching D beat.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset.
//   tl_i / tl_o         : TL-UL A channel + d_ready in, D channel + a_ready out.
//   reg_req_o           : register access active (only while in ACCESS).
//   reg_we_o            : 1 = write, 0 = read.
//   reg_addr_o          : word-aligned byte offset of the access in the window.
//   reg_wdata_o/reg_be_o: write data and byte enables of the captured beat.
//   reg_rvalid_i        : access complete; reg_rdata_i/reg_err_i sampled with it.
// Flow: IDLE accepts a beat; illegal beats go straight to RESP with d_error,
// legal ones to ACCESS until reg_rvalid_i or TimeoutCycles ACCESS cycles.
// -----------------------------------------------------------------------------
module tlul_dev_responder
    import tlul_pkg::*;
    import tlul_dev_pkg::*;
#(
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [31:0] AddrMask      = 32'h0000_0FFF,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_be_o,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    // Counter only has to reach TimeoutCycles-1 (cycles are counted from 0).
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rdy_q, rdy_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      size_q, size_d;
    logic [7:0]      source_q, source_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
    err_cause_e      cause_q, cause_d;
    logic            rerr_q, rerr_d;
    logic [31:0]     resp_data_q, resp_data_d;

    logic            chk_err;
    err_cause_e      chk_cause;
    logic            a_ready;
    logic            accept;
    logic            in_access;

    tlul_dev_err_chk #(
        .BaseAddr (BaseAddr),
        .AddrMask (AddrMask)
    ) u_err_chk (
        .a_opcode  (tl_i.a_opcode),
        .a_size    (tl_i.a_size),
        .a_address (tl_i.a_address),
        .a_mask    (tl_i.a_mask),
        .err_o     (chk_err),
        .cause_o   (chk_cause)
    );

    // rdy_q keeps a_ready low while in reset and rises on the first edge after.
    assign a_ready   = rdy_q && (state_q == ST_IDLE);
    assign accept    = tl_i.a_valid && a_ready;
    assign in_access = (state_q == ST_ACCESS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdy_d       = 1'b1;
        op_d        = op_q;
        size_d      = size_q;
        source_d    = source_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        cause_d     = cause_q;
        rerr_d      = rerr_q;
        resp_data_d = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = tl_i.a_opcode;
                    size_d   = tl_i.a_size;
                    source_d = tl_i.a_source;
                    addr_d   = tl_i.a_address;
                    mask_d   = tl_i.a_mask;
                    wdata_d  = tl_i.a_data;
                    cause_d  = chk_cause;
                    rerr_d   = 1'b0;
                    cnt_d    = '0;
                    if (chk_err) begin
                        state_d     = ST_RESP;
                        resp_data_d = (tl_i.a_opcode == OpGet) ? 32'hFFFF_FFFF : 32'h0;
                    end else begin
                        state_d     = ST_ACCESS;
                        resp_data_d = 32'h0;
                    end
                end
            end
            ST_ACCESS: begin
                // A completion in the last allowed cycle beats the timeout.
                if (reg_rvalid_i) begin
                    state_d     = ST_RESP;
                    rerr_d      = reg_err_i;
                    resp_data_d = (op_q == OpGet) ? reg_rdata_i : 32'h0;
                end else if (cnt_q == CntLast) begin
                    state_d     = ST_RESP;
                    cause_d     = ERR_TIMEOUT;
                    resp_data_d = 32'hFFFF_FFFF;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_RESP: begin
                if (tl_i.d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            op_q        <= 3'd0;
            size_q      <= 2'd0;
            source_q    <= 8'd0;
            addr_q      <= 32'd0;
            mask_q      <= 4'd0;
            wdata_q     <= 32'd0;
            cause_q     <= ERR_NONE;
            rerr_q      <= 1'b0;
            resp_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            op_q        <= op_d;
            size_q      <= size_d;
            source_q    <= source_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            cause_q     <= cause_d;
            rerr_q      <= rerr_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = (state_q == ST_RESP);
        tl_o.d_opcode = (op_q == OpGet) ? OpAccessAckData : OpAccessAck;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_data   = resp_data_q;
        tl_o.d_error  = (cause_q != ERR_NONE) || rerr_q;
    end

    // Register-side fields are forced to zero outside ACCESS so the register
    // block never sees stale request data.
    assign reg_req_o   = in_access;
    assign reg_we_o    = in_access && (op_q != OpGet);
    assign reg_addr_o  = in_access ? (addr_q & AddrMask & 32'hFFFF_FFFC) : 32'h0;
    assign reg_wdata_o = in_access ? wdata_q : 32'h0;
    assign reg_be_o    = in_access ? mask_q : 4'h0;

endmodule

// File: tb/tb_tlul_dev_responder.sv
// -----------------------------------------------------------------------------
// tb_tlul_dev_responder
// Two responders share one stimulus path: dut_a keeps the default timeout,
// dut_b uses TimeoutCycles = 4. `sel` picks which one receives the A beat and
// whose outputs are observed. Expected responses come from a transaction-level
// model of the device rules and are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_tlul_dev_responder;
    import tlul_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int TO_A = 255;
    localparam int TO_B = 4;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          rv_dly;   // ACCESS cycle (0-based) that gets reg_rvalid_i
        logic [31:0] rdata;
        logic        rerr;
        int          dr_dly;   // cycles d_ready is held low once d_valid is up
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    tlul_dev_responder_if bus_a ();
    tlul_dev_responder_if bus_b ();

    tl_h2d_t     h2d;
    tl_d2h_t     d2h;
    logic        sel;
    logic        reg_rvalid;
    logic [31:0] reg_rdata;
    logic        reg_err;

    logic        req_a, we_a, req_b, we_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [3:0]  be_a, be_b;
    logic        reg_req, reg_we;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_be;

    always_comb begin
        bus_a.h2d         = h2d;
        bus_a.h2d.a_valid = h2d.a_valid && !sel;
        bus_b.h2d         = h2d;
        bus_b.h2d.a_valid = h2d.a_valid && sel;
        d2h       = sel ? bus_b.d2h : bus_a.d2h;
        reg_req   = sel ? req_b : req_a;
        reg_we    = sel ? we_b : we_a;
        reg_addr  = sel ? addr_b : addr_a;
        reg_wdata = sel ? wdata_b : wdata_a;
        reg_be    = sel ? be_b : be_a;
    end

    tlul_dev_responder #(
        .BaseAddr (BASE), .AddrMask (32'h0000_0FFF), .TimeoutCycles (TO_A)
    ) dut_a (
        .clk_i (clk), .rst_i (rst), .tl_i (bus_a.h2d), .tl_o (bus_a.d2h),
        .reg_req_o (req_a), .reg_we_o (we_a), .reg_addr_o (addr_a),
        .reg_wdata_o (wdata_a), .reg_be_o (be_a), .reg_rvalid_i (reg_rvalid),
        .reg_rdata_i (reg_rdata), .reg_err_i (reg_err)
    );

    tlul_dev_responder #(
        .BaseAddr (BASE), .AddrMask (32'h0000_0FFF), .TimeoutCycles (TO_B)
    ) dut_b (
        .clk_i (clk), .rst_i (rst), .tl_i (bus_b.h2d), .tl_o (bus_b.d2h),
        .reg_req_o (req_b), .reg_we_o (we_b), .reg_addr_o (addr_b),
        .reg_wdata_o (wdata_b), .reg_be_o (be_b), .reg_rvalid_i (reg_rvalid),
        .reg_rdata_i (reg_rdata), .reg_err_i (reg_err)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] exp_q[$];   // {d_error, d_opcode, d_data}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_illegal(input txn_t t);
        int unsigned bytes;
        int unsigned lanes;
        if (!(t.op == 3'd4 || t.op == 3'd0 || t.op == 3'd1)) return 1'b1;
        if (t.size > 2'd2) return 1'b1;
        bytes = 1 << t.size;
        if ((t.addr % bytes) != 0) return 1'b1;
        if (t.mask == 4'd0) return 1'b1;
        lanes = ((1 << bytes) - 1) << (t.addr % 4);
        if (t.op == 3'd0 && 32'(t.mask) != lanes) return 1'b1;
        if (t.addr < BASE || t.addr >= BASE + 32'h1000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_req_cycles(input txn_t t, input int to);
        if (model_illegal(t)) return 0;
        return (t.rv_dly < to) ? t.rv_dly + 1 : to;
    endfunction

    function automatic logic [35:0] model_resp(input txn_t t, input int to);
        logic        err;
        logic [2:0]  op;
        logic [31:0] data;
        op = (t.op == 3'd4) ? 3'd1 : 3'd0;
        if (model_illegal(t)) begin
            err  = 1'b1;
            data = (t.op == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
        end else if (t.rv_dly >= to) begin
            err  = 1'b1;
            data = 32'hFFFF_FFFF;
        end else begin
            err  = t.rerr;
            data = (t.op == 3'd4) ? t.rdata : 32'h0;
        end
        return {err, op, data};
    endfunction

    function automatic txn_t mk(input logic [2:0] op, input logic [1:0] size,
                                input logic [7:0] src, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data,
                                input int rv_dly, input logic [31:0] rdata,
                                input logic rerr, input int dr_dly);
        txn_t t;
        t.op = op; t.size = size; t.src = src; t.addr = addr; t.mask = mask;
        t.data = data; t.rv_dly = rv_dly; t.rdata = rdata; t.rerr = rerr;
        t.dr_dly = dr_dly;
        return t;
    endfunction

    // ---------------- driver / monitor ----------------
    task automatic run_txn(input txn_t t);
        int          to, guard, m, req_cnt;
        logic        bad_ardy, unstable, seen_we;
        logic [3:0]  seen_be;
        logic [31:0] seen_addr, seen_wdata;
        logic [35:0] exp_w;
        tl_d2h_t     snap;
        bit          illegal;

        to      = sel ? TO_B : TO_A;
        illegal = model_illegal(t);
        exp_q.push_back(model_resp(t, to));

        @(negedge clk);
        h2d.a_opcode  = t.op;
        h2d.a_size    = t.size;
        h2d.a_source  = t.src;
        h2d.a_address = t.addr;
        h2d.a_mask    = t.mask;
        h2d.a_data    = t.data;
        h2d.a_valid   = 1'b1;
        reg_rdata     = t.rdata;
        reg_err       = t.rerr;

        guard = 0;
        while (!d2h.a_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", guard < 20, 1);
        if (guard >= 20) begin
            h2d.a_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end

        // The next rising edge takes the beat; m counts cycles after it.
        @(negedge clk);
        h2d.a_valid = 1'b0;
        m = 1; req_cnt = 0; bad_ardy = 1'b0;
        seen_we = 1'b0; seen_be = 4'h0; seen_addr = 32'h0; seen_wdata = 32'h0;
        while (!d2h.d_valid && m < 40) begin
            if (d2h.a_ready) bad_ardy = 1'b1;
            if (reg_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    seen_we = reg_we; seen_be = reg_be;
                    seen_addr = reg_addr; seen_wdata = reg_wdata;
                end
                reg_rvalid = (req_cnt - 1 == t.rv_dly);
            end
            @(negedge clk);
            reg_rvalid = 1'b0;
            m++;
        end
        check("dvalid_wait", m < 40, 1);
        check("req_cycles", req_cnt, model_req_cycles(t, to));
        check("dvalid_latency", m, illegal ? 1 : model_req_cycles(t, to) + 1);
        check("ardy_busy", bad_ardy, 0);
        if (!illegal) begin
            check("reg_we", seen_we, t.op != 3'd4);
            check("reg_be", seen_be, t.mask);
            check("reg_addr", seen_addr, (t.addr - BASE) & 32'hFFFF_FFFC);
            check("reg_wdata", seen_wdata, t.data);
        end

        exp_w = exp_q.pop_front();
        check("d_error", d2h.d_error, exp_w[35]);
        check("d_opcode", d2h.d_opcode, exp_w[34:32]);
        check("d_data", d2h.d_data, exp_w[31:0]);
        check("d_source", d2h.d_source, t.src);
        check("d_size", d2h.d_size, t.size);
        check("d_param_sink", {d2h.d_param, d2h.d_sink}, 0);

        // Hold off d_ready while offering another beat that must not be taken.
        snap = d2h;
        unstable = 1'b0;
        if (t.dr_dly > 0) begin
            h2d.a_opcode = 3'd4; h2d.a_size = 2'd2; h2d.a_address = BASE;
            h2d.a_mask = 4'hF; h2d.a_valid = 1'b1;
        end
        for (int k = 0; k < t.dr_dly; k++) begin
            @(negedge clk);
            if (d2h !== snap || reg_req) unstable = 1'b1;
        end
        check("d_hold_stable", unstable, 0);
        h2d.a_valid = 1'b0;
        h2d.d_ready = 1'b1;
        @(negedge clk);
        h2d.d_ready = 1'b0;
        check("dvalid_drop", d2h.d_valid, 0);
        check("ardy_after", d2h.a_ready, 1);
    endtask

    task automatic reset_mid(input bit in_resp);
        int   guard;
        logic saw_dvalid;
        sel = 1'b0;
        @(negedge clk);
        h2d.a_opcode = 3'd4; h2d.a_size = 2'd2; h2d.a_source = 8'd1;
        h2d.a_address = BASE + 32'h8; h2d.a_mask = 4'hF; h2d.a_valid = 1'b1;
        guard = 0;
        while (!d2h.a_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_accept_wait", guard < 20, 1);
        @(negedge clk);
        h2d.a_valid = 1'b0;
        if (in_resp) begin
            reg_rvalid = 1'b1;
            @(negedge clk);
            reg_rvalid = 1'b0;
            check("rst_pre_resp", d2h.d_valid, 1);
        end else begin
            check("rst_pre_access", reg_req, 1);
        end
        rst = 1'b1;
        #1;
        check("rst_async_req", reg_req, 0);
        check("rst_async_dvalid", d2h.d_valid, 0);
        check("rst_async_ardy", d2h.a_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ardy_release", d2h.a_ready, 1);
        saw_dvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (d2h.d_valid || reg_req) saw_dvalid = 1'b1;
            @(negedge clk);
        end
        check("rst_no_response", saw_dvalid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        txn_t t;
        h2d = '0; sel = 1'b0;
        reg_rvalid = 1'b0; reg_rdata = 32'h0; reg_err = 1'b0;

        @(negedge clk);
        check("reset_ardy_a", bus_a.d2h.a_ready, 0);
        check("reset_ardy_b", bus_b.d2h.a_ready, 0);
        check("reset_dvalid_a", bus_a.d2h.d_valid, 0);
        check("reset_req_a", req_a, 0);
        check("reset_d2h_a", bus_a.d2h, 0);
        check("reset_regs_a", {we_a, addr_a, wdata_a, be_a}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("release_ardy_a", bus_a.d2h.a_ready, 1);
        check("release_ardy_b", bus_b.d2h.a_ready, 1);

        // Zero-wait Get
        run_txn(mk(3'd4, 2'd2, 8'd3, BASE + 32'h10, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0));
        // Partial put with slow completion
        run_txn(mk(3'd1, 2'd2, 8'd7, BASE + 32'h4, 4'b0011, 32'h1234_5678, 5, 32'h0, 1'b0, 0));
        // Illegal beats
        run_txn(mk(3'd3, 2'd2, 8'd1, BASE, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd4, 2'd3, 8'd2, BASE, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd4, 2'd2, 8'd3, BASE + 32'h2, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd0, 2'd2, 8'd4, BASE, 4'b0111, 32'h55, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd4, 2'd2, 8'd5, BASE + 32'h1000, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd1, 2'd2, 8'd6, BASE + 32'h8, 4'h0, 32'h0, 0, 32'h0, 1'b0, 0));
        // Sub-word legal accesses and a register-side error
        run_txn(mk(3'd4, 2'd0, 8'd8, BASE + 32'h3, 4'b1000, 32'h0, 1, 32'hA5A5_0001, 1'b0, 0));
        run_txn(mk(3'd0, 2'd1, 8'd9, BASE + 32'h22, 4'b1100, 32'hBEEF_0000, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd4, 2'd2, 8'd10, BASE + 32'hFFC, 4'hF, 32'h0, 2, 32'h0BAD_0BAD, 1'b1, 0));
        // Timeout device: withheld, last-cycle completion, put timeout
        sel = 1'b1;
        run_txn(mk(3'd4, 2'd2, 8'd11, BASE + 32'h20, 4'hF, 32'h0, 9, 32'h1111_1111, 1'b0, 0));
        run_txn(mk(3'd4, 2'd2, 8'd12, BASE + 32'h20, 4'hF, 32'h0, 3, 32'h2222_2222, 1'b0, 0));
        run_txn(mk(3'd0, 2'd2, 8'd13, BASE + 32'h24, 4'hF, 32'h77, 4, 32'h0, 1'b0, 0));
        // Response back-pressure
        sel = 1'b0;
        run_txn(mk(3'd4, 2'd2, 8'd14, BASE + 32'h30, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 10));
        // Reset abandoning a transaction
        reset_mid(1'b0);
        reset_mid(1'b1);

        // Randomized traffic on both devices
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ops [9];
            logic [31:0] off;
            ops = '{3'd4, 3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd3, 3'd2, 3'd5};
            sel      = 1'($urandom_range(0, 1));
            t.op     = ops[$urandom_range(0, 8)];
            t.size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off      = 32'($urandom_range(0, 32'hFFF));
            if ($urandom_range(0, 4) != 0) off = off & ~((32'd1 << t.size) - 1);
            case ($urandom_range(0, 9))
                0:       t.addr = BASE + 32'h1000 + off;
                1:       t.addr = off;
                default: t.addr = BASE + off;
            endcase
            if ($urandom_range(0, 3) == 0) t.mask = 4'($urandom_range(0, 15));
            else if (t.size == 2'd0) t.mask = 4'b0001 << t.addr[1:0];
            else if (t.size == 2'd1) t.mask = t.addr[1] ? 4'b1100 : 4'b0011;
            else t.mask = 4'hF;
            t.src    = 8'($urandom_range(0, 255));
            t.data   = $urandom;
            t.rdata  = $urandom;
            t.rerr   = ($urandom_range(0, 5) == 0);
            t.rv_dly = $urandom_range(0, 7);
            t.dr_dly = $urandom_range(0, 3);
            run_txn(t);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tlul_dev_responder.md
TLUL_DEV_RESPONDER -- requirements
Module: tlul_dev_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  - BaseAddr, 32'h0, device window base.
  - AddrMask, 32'h0000_0FFF, window size mask; a hit is (a_address & ~AddrMask) == BaseAddr.
  - TimeoutCycles, 255, maximum cycles to wait for reg_rvalid_i; legal range >= 1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk_i, in, 1, the single clock.
  - rst_i, in, 1, asynchronous active-high reset.
  - tl_i, in, tlul_pkg::tl_h2d_t, A channel plus d_ready.
  - tl_o, out, tlul_pkg::tl_d2h_t, D channel plus a_ready.
  - reg_req_o, out, 1, register access active.
  - reg_we_o, out, 1, 1 = write, 0 = read.
  - reg_addr_o, out, 32, captured word address (offset within window).
  - reg_wdata_o, out, 32, write data.
  - reg_be_o, out, 4, byte enables (captured a_mask).
  - reg_rvalid_i, in, 1, access complete.
  - reg_rdata_i, in, 32, read data, sampled with reg_rvalid_i.
  - reg_err_i, in, 1, register-side error, sampled with reg_rvalid_i.

Function
REQ-003 The block SHALL implement FSM states IDLE, ACCESS and RESP, with one transaction outstanding at a time.
REQ-004 tl_o.a_ready SHALL be 1 only in IDLE. An A beat is accepted when a_valid && a_ready; on acceptance, opcode, size, source, address, mask and data SHALL be captured.
REQ-005 An accepted beat SHALL be flagged as an error if any of the following holds:
  - opcode is not Get(4), PutFullData(0) or PutPartialData(1);
  - a_size > 2;
  - address is misaligned for a_size;
  - PutFullData mask is not all-ones for a_size;
  - mask is zero;
  - the address misses the window.
REQ-006 A flagged beat SHALL go IDLE -> RESP with no register access and d_error = 1; for Get, d_data SHALL be 32'hFFFF_FFFF.
REQ-007 A good beat SHALL go IDLE -> ACCESS. In ACCESS:
  - reg_req_o = 1, with reg_we_o/addr/wdata/be driven from the captured fields;
  - the state is held until reg_rvalid_i, then -> RESP;
  - rdata and reg_err_i are captured in that cycle.
REQ-008 reg_rvalid_i SHALL be accepted in the first ACCESS cycle (zero wait). Minimum latency SHALL therefore be accept at cycle N, d_valid at cycle N+2.
REQ-009 A counter SHALL count ACCESS cycles, cleared on entering ACCESS. If the count reaches TimeoutCycles without reg_rvalid_i, the FSM SHALL go -> RESP with d_error = 1, d_data = 32'hFFFF_FFFF, and reg_req_o deasserting the same cycle. If reg_rvalid_i arrives in that same cycle, rvalid SHALL win.
REQ-010 In RESP, d_valid SHALL be 1 with all D fields stable until d_ready; on d_valid && d_ready -> IDLE. A new A beat SHALL be accepted no earlier than the following cycle.
REQ-011 D fields SHALL be:
  - d_opcode = AccessAckData(1) for Get, AccessAck(0) otherwise (including error responses to illegal opcodes);
  - d_size and d_source echo the captured values;
  - d_param = 0, d_sink = 0;
  - d_data = captured rdata for a good Get, 0 for Put;
  - d_error = check error OR reg_err_i OR timeout.
REQ-012 reg_req_o SHALL never assert outside ACCESS, and only one register access SHALL occur per accepted beat.

Reset
REQ-013 rst_i SHALL asynchronously force IDLE and clear the counter and all captured fields.
REQ-014 During reset all outputs SHALL be 0 (tl_o.a_ready = 0, d_valid = 0, reg_req_o = 0); after release, a_ready = 1 from the first clock edge.
REQ-015 Reset asserted mid-ACCESS or mid-RESP SHALL abandon the transaction with no response issued.

Structure
REQ-016 TL-UL opcode constants and structs SHALL come from tlul_pkg. The FSM state enum and the error-cause enum (ERR_NONE, ERR_OPCODE, ERR_ALIGN, ERR_MASK, ERR_RANGE, ERR_TIMEOUT) SHALL live in a shared tlul_dev_pkg.
REQ-017 The combinational A-beat legality check SHALL be one sub-module, tlul_dev_err_chk (inputs: A fields plus parameters; output: error flag and cause).

Verification
REQ-018 Get @BaseAddr+0x10, size 2, source 3, rvalid in the same cycle with rdata 32'hDEAD_BEEF -> reg_we_o = 0, d_valid at N+2, d_opcode 1, d_data DEAD_BEEF, d_source 3, d_error 0.
REQ-019 PutPartialData @+0x4, mask 4'b0011, data 32'h1234_5678, rvalid after 5 cycles -> reg_be_o 0011, d_opcode 0, d_error 0, a_ready low throughout.
REQ-020 Each illegal case (opcode 3, size 3, address ending 0x2 at size 2, PutFull mask 4'b0111, address BaseAddr+0x1000) -> reg_req_o never asserts, d_error 1.
REQ-021 TimeoutCycles = 4 with rvalid withheld -> reg_req_o high exactly 4 cycles, d_error 1, d_data FFFF_FFFF; a variant with rvalid in cycle 4 -> d_error 0.
REQ-022 Response back-pressure with d_ready low for 10 cycles -> D fields stable, no second beat accepted; rst_i pulsed in ACCESS -> IDLE, no d_valid, a_ready 1 after release.
